// File: rtl/ssd_scroll_if.sv
// ---------------------------------------------------------------------------
// ssd_scroll_if
// Groups the control/data signals between the scroll sequencer and whoever
// drives it (frequency divider, message loader, user control).
//
// Signals:
//   tick      scroll-rate strobe, one clk wide
//   wr_en     message write strobe
//   wr_addr   message write index
//   wr_data   message symbol (4 bits)
//   msg_len   valid symbol count, legal 1..MSG_DEPTH (ADDR_W+1 bits)
//   loop      1 = wrap to symbol 0 at end of message
//   start     start / resume / restart request (level)
//   stop      pause / abort request (level)
//   digit3..0 window symbols; digit3 = leftmost
//   busy      sequencer is running or paused
//   wrap      one-clk pulse when the pointer wraps to 0
//   done      high while the message has finished (non-looping)
//
// Handshake: there is no valid/ready pair here. Every input is a level that
// is sampled on each rising clk edge; tick and wr_en are one-cycle strobes.
// Outputs are registered (busy/done decode the registered state).
//
// Modports:
//   master  drives the controls, observes the display outputs
//   slave   the sequencer itself
// ---------------------------------------------------------------------------
interface ssd_scroll_if #(
  parameter int ADDR_W = 4
);
  logic              tick;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [3:0]        wr_data;
  logic [ADDR_W:0]   msg_len;
  logic              loop;
  logic              start;
  logic              stop;
  logic [3:0]        digit3;
  logic [3:0]        digit2;
  logic [3:0]        digit1;
  logic [3:0]        digit0;
  logic              busy;
  logic              wrap;
  logic              done;

  modport master (
    output tick, wr_en, wr_addr, wr_data, msg_len, loop, start, stop,
    input  digit3, digit2, digit1, digit0, busy, wrap, done
  );

  modport slave (
    input  tick, wr_en, wr_addr, wr_data, msg_len, loop, start, stop,
    output digit3, digit2, digit1, digit0, busy, wrap, done
  );
endinterface

// File: rtl/ssd_scroll_ctrl.sv
// ---------------------------------------------------------------------------
// ssd_scroll_ctrl
// Digit source for the 4-digit seven-segment path. Stores a message of up to
// MSG_DEPTH 4-bit symbols and presents a 4-symbol window that advances one
// position per scroll tick, with start/pause/stop control and optional
// looping.
//
// Ports:
//   clk          system clock
//   rst_n        synchronous active-low reset
//   bus          ssd_scroll_if.slave (controls in, digits/status out)
//   o_dbg_state  current FSM state (0 IDLE, 1 RUN, 2 PAUSE, 3 DONE)
//
// Optional feature macro: SSD_SCROLL_BLINK_EN
//   When defined, each tick in PAUSE toggles the digits between the window
//   and all-blank. When undefined, PAUSE holds the window steady.
// ---------------------------------------------------------------------------
module ssd_scroll_ctrl #(
  parameter int         MSG_DEPTH  = 16,
  parameter int         ADDR_W     = 4,
  parameter logic [3:0] BLANK_CODE = 4'hF
) (
  input  logic               clk,
  input  logic               rst_n,
  ssd_scroll_if.slave        bus,
  output logic [1:0]         o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W:0] PTR_ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] DEPTH_VAL = (ADDR_W+1)'(MSG_DEPTH);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [3:0]        r_mem [MSG_DEPTH];
  logic [ADDR_W:0]   r_ptr;
  logic [ADDR_W:0]   r_len;
  logic              r_loop;
  logic [15:0]       r_digits;
  logic              r_wrap;

  logic [ADDR_W:0]   w_ptr_nxt;
  logic [ADDR_W:0]   w_len_nxt;
  logic              w_loop_nxt;
  logic              w_load;
  logic              w_blank;
  logic              w_wrap_nxt;
  logic              w_start_ok;
  logic              w_at_end;
  logic [ADDR_W:0]   w_idx [4];
  logic [3:0]        w_sym [4];
  logic [15:0]       w_win;

`ifdef SSD_SCROLL_BLINK_EN
  logic              r_blink_off;
  logic              w_blink_off_nxt;
`endif

  // A start is only honoured when the requested length is usable.
  assign w_start_ok = bus.start && (bus.msg_len != '0) && (bus.msg_len <= DEPTH_VAL);
  assign w_at_end   = ((r_ptr + PTR_ONE) == r_len);

  // -------------------------------------------------------------------------
  // Next-state / control
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_len_nxt   = r_len;
    w_loop_nxt  = r_loop;
    w_load      = 1'b0;
    w_blank     = 1'b0;
    w_wrap_nxt  = 1'b0;
`ifdef SSD_SCROLL_BLINK_EN
    w_blink_off_nxt = 1'b0;
`endif
    unique case (r_state)
      S_IDLE: begin
        if (!bus.stop && w_start_ok) begin
          w_len_nxt   = bus.msg_len;
          w_loop_nxt  = bus.loop;
          w_ptr_nxt   = '0;
          w_load      = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (bus.stop) begin
          w_state_nxt = S_PAUSE;
        end else if (bus.tick) begin
          if (!w_at_end) begin
            w_ptr_nxt = r_ptr + PTR_ONE;
            w_load    = 1'b1;
          end else if (r_loop) begin
            w_ptr_nxt  = '0;
            w_load     = 1'b1;
            w_wrap_nxt = 1'b1;
          end else begin
            w_state_nxt = S_DONE;
          end
        end
      end
      S_PAUSE: begin
        if (bus.stop) begin
          w_blank     = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (bus.start) begin
          // Reload so symbols written while paused become visible.
          w_load      = 1'b1;
          w_state_nxt = S_RUN;
        end
`ifdef SSD_SCROLL_BLINK_EN
        else if (bus.tick) begin
          w_blink_off_nxt = ~r_blink_off;
          if (r_blink_off) begin
            w_load = 1'b1;
          end else begin
            w_blank = 1'b1;
          end
        end else begin
          w_blink_off_nxt = r_blink_off;
        end
`endif
      end
      S_DONE: begin
        if (bus.stop) begin
          w_blank     = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (w_start_ok) begin
          w_len_nxt   = bus.msg_len;
          w_loop_nxt  = bus.loop;
          w_ptr_nxt   = '0;
          w_load      = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_blank     = 1'b1;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Window symbol indices from the next pointer/length. p < L always holds,
  // so p+3 can exceed L by up to three multiples when L is 1; three rounds of
  // compare-and-subtract cover every case.
  // -------------------------------------------------------------------------
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      w_idx[k] = w_ptr_nxt + (ADDR_W+1)'(k);
      for (int j = 0; j < 3; j++) begin
        if (w_idx[k] >= w_len_nxt) begin
          w_idx[k] = w_idx[k] - w_len_nxt;
        end
      end
    end
  end

  // Full-width compare per storage slot keeps the index width honest.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      w_sym[k] = BLANK_CODE;
      for (int m = 0; m < MSG_DEPTH; m++) begin
        if (w_idx[k] == (ADDR_W+1)'(m)) begin
          w_sym[k] = r_mem[m];
        end
      end
    end
  end

  assign w_win = {w_sym[0], w_sym[1], w_sym[2], w_sym[3]};

  // -------------------------------------------------------------------------
  // State and datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_ptr    <= '0;
      r_len    <= PTR_ONE;
      r_loop   <= 1'b0;
      r_digits <= {4{BLANK_CODE}};
      r_wrap   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_len   <= w_len_nxt;
      r_loop  <= w_loop_nxt;
      r_wrap  <= w_wrap_nxt;
      if (w_blank) begin
        r_digits <= {4{BLANK_CODE}};
      end else if (w_load) begin
        r_digits <= w_win;
      end
    end
  end

`ifdef SSD_SCROLL_BLINK_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_blink_off <= 1'b0;
    end else begin
      r_blink_off <= w_blink_off_nxt;
    end
  end
`endif

  // Message storage: writes are dropped while scrolling so the visible
  // message cannot tear mid-run.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int m = 0; m < MSG_DEPTH; m++) begin
        r_mem[m] <= BLANK_CODE;
      end
    end else if (bus.wr_en && (r_state != S_RUN)) begin
      r_mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus.digit3  = r_digits[15:12];
  assign bus.digit2  = r_digits[11:8];
  assign bus.digit1  = r_digits[7:4];
  assign bus.digit0  = r_digits[3:0];
  assign bus.busy    = (r_state == S_RUN) || (r_state == S_PAUSE);
  assign bus.done    = (r_state == S_DONE);
  assign bus.wrap    = r_wrap;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_ssd_scroll_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ssd_scroll_ctrl
// Directed bench for ssd_scroll_ctrl: scrolling with and without looping,
// pause/resume/abort, illegal lengths, short messages, write gating,
// mid-run reset and a full-depth message with wrap.
// ---------------------------------------------------------------------------
module tb_ssd_scroll_ctrl;

  localparam int ADDR_W = 4;

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;

  int n_total = 0;
  int n_bad   = 0;

  logic [15:0] exp_q[$];

  ssd_scroll_if #(.ADDR_W(ADDR_W)) bus ();

  ssd_scroll_ctrl #(
    .MSG_DEPTH (16),
    .ADDR_W    (ADDR_W),
    .BLANK_CODE(4'hF)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus.slave),
    .o_dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  // Advance one clock; inputs change and outputs are sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] digits();
    return {bus.digit3, bus.digit2, bus.digit1, bus.digit0};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic wr(input logic [3:0] addr, input logic [3:0] data);
    bus.wr_en   = 1'b1;
    bus.wr_addr = addr;
    bus.wr_data = data;
    step();
    bus.wr_en   = 1'b0;
  endtask

  task automatic do_start(input logic [4:0] len, input logic lp);
    bus.msg_len = len;
    bus.loop    = lp;
    bus.start   = 1'b1;
    step();
    bus.start   = 1'b0;
  endtask

  task automatic do_tick();
    bus.tick = 1'b1;
    step();
    bus.tick = 1'b0;
  endtask

  task automatic do_stop();
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n       = 1'b0;
    bus.tick    = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.msg_len = '0;
    bus.loop    = 1'b0;
    bus.start   = 1'b0;
    bus.stop    = 1'b0;
    step();
    step();
    rst_n = 1'b1;

    // Reset state
    check("rst_digits", digits(), 16'hFFFF);
    check("rst_busy",   bus.busy, 1'b0);
    check("rst_done",   bus.done, 1'b0);
    check("rst_wrap",   bus.wrap, 1'b0);
    check("rst_state",  dbg_state, 2'd0);

    // Looping scroll of 0,1,2,3,4
    for (int i = 0; i < 5; i++) wr(4'(i), 4'(i));
    do_start(5'd5, 1'b1);
    check("loop_start", digits(), 16'h0123);
    check("loop_busy",  bus.busy, 1'b1);
    exp_q = {16'h1234, 16'h2340, 16'h3401, 16'h4012};
    while (exp_q.size() > 0) begin
      do_tick();
      check("loop_win",  digits(), exp_q.pop_front());
      check("loop_nowrap", bus.wrap, 1'b0);
    end
    do_tick();
    check("wrap_win",   digits(), 16'h0123);
    check("wrap_pulse", bus.wrap, 1'b1);
    step();
    check("wrap_clear", bus.wrap, 1'b0);
    do_stop();
    check("pause_state", dbg_state, 2'd2);
    do_stop();
    check("abort_digits", digits(), 16'hFFFF);

    // Non-looping: ends in DONE holding last window
    do_start(5'd5, 1'b0);
    check("once_start", digits(), 16'h0123);
    for (int i = 0; i < 4; i++) do_tick();
    check("once_last", digits(), 16'h4012);
    do_tick();
    check("done_flag",   bus.done, 1'b1);
    check("done_busy",   bus.busy, 1'b0);
    check("done_digits", digits(), 16'h4012);
    check("done_wrap",   bus.wrap, 1'b0);
    do_start(5'd5, 1'b0);
    check("restart_win",  digits(), 16'h0123);
    check("restart_done", bus.done, 1'b0);
    check("restart_busy", bus.busy, 1'b1);

    // Stop wins over a simultaneous tick
    do_tick();
    check("run_1234", digits(), 16'h1234);
    bus.tick = 1'b1;
    bus.stop = 1'b1;
    step();
    bus.tick = 1'b0;
    bus.stop = 1'b0;
    check("stop_tick_state", dbg_state, 2'd2);
    check("stop_tick_win",   digits(), 16'h1234);
    check("pause_busy",      bus.busy, 1'b1);
    do_tick();
`ifdef SSD_SCROLL_BLINK_EN
    check("blink_off", digits(), 16'hFFFF);
    do_tick();
    check("blink_on",  digits(), 16'h1234);
    do_tick();
    check("blink_off2", digits(), 16'hFFFF);
`else
    check("pause_hold", digits(), 16'h1234);
`endif
    do_start(5'd5, 1'b0);
    check("resume_win",   digits(), 16'h1234);
    check("resume_state", dbg_state, 2'd1);
    do_tick();
    check("resume_tick", digits(), 16'h2340);
    do_stop();
    do_stop();
    check("idle_digits", digits(), 16'hFFFF);
    check("idle_busy",   bus.busy, 1'b0);

    // Illegal lengths are ignored
    do_start(5'd0, 1'b0);
    check("len0_state",  dbg_state, 2'd0);
    check("len0_digits", digits(), 16'hFFFF);
    do_start(5'd17, 1'b0);
    check("len17_state",  dbg_state, 2'd0);
    check("len17_digits", digits(), 16'hFFFF);

    // Two-symbol message repeats
    wr(4'd0, 4'd7);
    wr(4'd1, 4'd8);
    do_start(5'd2, 1'b0);
    check("len2_win", digits(), 16'h7878);

    // Writes dropped in RUN, accepted in PAUSE
    wr(4'd0, 4'd9);
    do_stop();
    do_start(5'd2, 1'b0);
    check("run_write_drop", digits(), 16'h7878);
    do_stop();
    wr(4'd1, 4'd9);
    do_start(5'd2, 1'b0);
    check("pause_write", digits(), 16'h7979);
    do_tick();
    check("len2_tick", digits(), 16'h9797);
    do_tick();
    check("len2_done", bus.done, 1'b1);
    check("len2_hold", digits(), 16'h9797);
    do_stop();
    check("done_stop", digits(), 16'hFFFF);

    // Reset in the middle of a run
    wr(4'd0, 4'd0);
    wr(4'd1, 4'd1);
    do_start(5'd5, 1'b1);
    do_tick();
    do_tick();
    check("pre_rst_win", digits(), 16'h2340);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("mid_rst_digits", digits(), 16'hFFFF);
    check("mid_rst_busy",   bus.busy, 1'b0);
    check("mid_rst_wrap",   bus.wrap, 1'b0);
    check("mid_rst_done",   bus.done, 1'b0);
    check("mid_rst_state",  dbg_state, 2'd0);

    // Full-depth message: memory came back blank, one marker at the top
    wr(4'd15, 4'd5);
    do_start(5'd16, 1'b1);
    check("full_start", digits(), 16'hFFFF);
    check("full_busy",  bus.busy, 1'b1);
    for (int i = 0; i < 12; i++) do_tick();
    check("full_p12", digits(), 16'hFFF5);
    do_tick();
    check("full_p13", digits(), 16'hFF5F);
    do_tick();
    do_tick();
    check("full_p15", digits(), 16'h5FFF);
    check("full_nowrap", bus.wrap, 1'b0);
    do_tick();
    check("full_wrap_win", digits(), 16'hFFFF);
    check("full_wrap",     bus.wrap, 1'b1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
